// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and line levels.
// Used by the transmitter and, later, by the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int   UART_DATA_BITS        = 8;
   localparam int   UART_CLKS_PER_BIT_DEF = 868;
   localparam logic UART_LINE_IDLE        = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clr is high so the first bit after a clear is full length.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, 1 or 2 stop bits, fixed baud.
// Define UART_TX_PARITY_EN to insert a parity bit (ODD_PARITY selects odd).
//
// state  | meaning
// IDLE   | line high, waiting for i_tx_start
// START  | start bit (low)
// DATA   | shifting out latched byte, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS stop bits (high)
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit ODD_PARITY   = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_tx,
   input  logic       i_tx_start,
   output logic       o_tx_start_clear,
   output logic       o_tx_busy,
   output logic       o_txd
);

   localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q;
   logic [2:0]  bit_idx_q;
   logic        clear_q;
   logic        bit_done;
   logic        accept;
   logic        txd;
`ifdef UART_TX_PARITY_EN
   logic        par_q;
`endif

   assign accept = (state_q == ST_IDLE) && i_tx_start;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clr      (state_q == ST_IDLE),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      txd     = UART_LINE_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (i_tx_start) state_d = ST_START;
         end
         ST_START: begin
            txd = 1'b0;
            if (bit_done) state_d = ST_DATA;
         end
         ST_DATA: begin
            txd = shift_q[0];
            if (bit_done && (bit_idx_q == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            txd = par_q;
            if (bit_done) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            txd = 1'b1;
            if (bit_done && (bit_idx_q == STOP_LAST)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // bit_idx_q counts data bits in DATA and stop bits in STOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q   <= '0;
         bit_idx_q <= '0;
         clear_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         clear_q <= accept;
         if (accept) begin
            shift_q   <= i_tx;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= (^i_tx) ^ ODD_PARITY;
`endif
         end else if (bit_done) begin
            if (state_q == ST_DATA) begin
               shift_q   <= shift_q >> 1;
               bit_idx_q <= (bit_idx_q == LAST_DATA) ? 3'd0 : bit_idx_q + 3'd1;
            end else if (state_q == ST_STOP) begin
               bit_idx_q <= bit_idx_q + 3'd1;
            end
         end
      end
   end

   assign o_txd            = txd;
   assign o_tx_busy        = (state_q != ST_IDLE);
   assign o_tx_start_clear = clear_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, hand-written corner sequences and
// randomized traffic compared every cycle against a frame-level reference model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NDUT = 3;
   localparam bit PAR  = 1'b1;
`else
   localparam int NDUT = 2;
   localparam bit PAR  = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      i_tx;
   logic            i_tx_start;
   logic [NDUT-1:0] clr_w, busy_w, txd_w;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .i_tx(i_tx), .i_tx_start(i_tx_start),
      .o_tx_start_clear(clr_w[0]), .o_tx_busy(busy_w[0]), .o_txd(txd_w[0]));

   uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .i_tx(i_tx), .i_tx_start(i_tx_start),
      .o_tx_start_clear(clr_w[1]), .o_tx_busy(busy_w[1]), .o_txd(txd_w[1]));

`ifdef UART_TX_PARITY_EN
   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .ODD_PARITY(1'b1)) dut2 (
      .clk(clk), .rst(rst), .i_tx(i_tx), .i_tx_start(i_tx_start),
      .o_tx_start_clear(clr_w[2]), .o_tx_busy(busy_w[2]), .o_txd(txd_w[2]));
`endif

   // Per-instance configuration
   function automatic int cpb_of(int i);   return (i == 1) ? 2 : 4; endfunction
   function automatic int stops_of(int i); return (i == 1) ? 2 : 1; endfunction
   function automatic bit odd_of(int i);   return (i == 2);         endfunction
   function automatic int nbits(int i);    return 10 + int'(PAR) + stops_of(i) - 1; endfunction

   // Reference model: a frame is a list of line levels, each shown for cpb cycles.
   typedef struct {
      int          rem;
      int          total;
      logic [15:0] bits;
      logic        clr;
   } mdl_t;
   mdl_t m[NDUT];

   function automatic logic [15:0] frame_of(int i, logic [7:0] d);
      logic [15:0] f = '1;
      f[0] = 1'b0;
      for (int j = 0; j < 8; j++) f[1+j] = d[j];
      if (PAR) f[9] = (^d) ^ odd_of(i);
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++) begin
         m[i].rem = 0; m[i].total = 0; m[i].bits = '1; m[i].clr = 1'b0;
      end
   endtask

   task automatic model_edge(logic s, logic [7:0] d);
      for (int i = 0; i < NDUT; i++) begin
         m[i].clr = 1'b0;
         if (m[i].rem > 0) begin
            m[i].rem--;
         end else if (s) begin
            m[i].bits  = frame_of(i, d);
            m[i].total = nbits(i) * cpb_of(i);
            m[i].rem   = m[i].total;
            m[i].clr   = 1'b1;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic exp_txd;
      for (int i = 0; i < NDUT; i++) begin
         exp_txd = (m[i].rem > 0) ? m[i].bits[(m[i].total - m[i].rem) / cpb_of(i)] : 1'b1;
         chk($sformatf("%s_txd%0d", tag, i),  {31'd0, txd_w[i]},  {31'd0, exp_txd});
         chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy_w[i]}, {31'd0, (m[i].rem > 0)});
         chk($sformatf("%s_clr%0d", tag, i),  {31'd0, clr_w[i]},  {31'd0, m[i].clr});
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare on the falling edge.
   task automatic step(input logic s, input logic [7:0] d);
      i_tx_start = s;
      i_tx       = d;
      @(posedge clk);
      if (!rst) model_edge(s, d);
      @(negedge clk);
      check_outputs("cyc");
   endtask

   typedef struct {
      logic [7:0] d;
      logic [9:0] exp_frame;   // line levels in send order, bit 0 first (no parity)
      logic       exp_par;     // even parity of d
   } vec_t;
   vec_t vecs[8];

   // One frame on dut0 with a stray start pulse mid-DATA and i_tx scrambled after accept.
   task automatic run_vec(input vec_t v);
      int          f0;
      int          c;
      int          nclr;
      int          nbusy;
      logic [15:0] rx;
      logic [15:0] exp;
      logic        par_odd;
      f0 = nbits(0) * 4;
      nclr = 0; nbusy = 0; rx = '1; par_odd = 1'b0;
      for (int k = 0; k <= f0; k++) begin
         if (k == 0) step(1'b1, v.d);
         else if (k == 15) step(1'b1, 8'h3C);
         else step(1'b0, 8'($urandom));
         c = k + 1;
         if (busy_w[0]) nbusy++;
         if (clr_w[0]) nclr++;
         if (c <= f0 && ((c - 1) % 4) == 2) rx[(c-1)/4] = txd_w[0];
`ifdef UART_TX_PARITY_EN
         if (c == 9 * 4 + 3) par_odd = txd_w[2];
`endif
      end
      exp = PAR ? {5'h1f, 1'b1, v.exp_par, v.exp_frame[8:0]} : {6'h3f, v.exp_frame};
      chk($sformatf("vec_%02h_frame", v.d), {16'd0, rx}, {16'd0, exp});
      chk($sformatf("vec_%02h_busy_cycles", v.d), nbusy, f0);
      chk($sformatf("vec_%02h_clr_pulses", v.d), nclr, 1);
`ifdef UART_TX_PARITY_EN
      chk($sformatf("vec_%02h_odd_par", v.d), {31'd0, par_odd}, {31'd0, ~v.exp_par});
`endif
   endtask

   initial begin
      int f0;
      int clr2_pos;
      int nclr;
      int idle_gap;

      vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
      vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
      vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
      vecs[3] = '{8'h55, 10'b1010101010, 1'b0};
      vecs[4] = '{8'h07, 10'b1000001110, 1'b1};
      vecs[5] = '{8'h03, 10'b1000000110, 1'b0};
      vecs[6] = '{8'h01, 10'b1000000010, 1'b1};
      vecs[7] = '{8'h81, 10'b1100000010, 1'b0};

      model_reset();
      rst = 1'b1; i_tx_start = 1'b0; i_tx = 8'h00;
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst = 1'b0;

      // Nothing is sent while i_tx_start stays low.
      for (int k = 0; k < 6; k++) step(1'b0, 8'($urandom));

      for (int v = 0; v < 7; v++) run_vec(vecs[v]);

      // Back-to-back: start held high across the frame boundary.
      f0 = nbits(0) * 4;
      clr2_pos = 0; nclr = 0; idle_gap = 0;
      step(1'b1, 8'h00);
      if (clr_w[0]) nclr++;
      for (int k = 1; k <= 2 * f0 + 6; k++) begin
         step(k <= f0 + 1, 8'hFF);
         if (clr_w[0]) begin
            nclr++;
            if (clr2_pos == 0) clr2_pos = k + 1;
         end
         if (!busy_w[0] && (k + 1) <= 2 * f0 + 1) idle_gap++;
      end
      chk("b2b_second_clr_cycle", clr2_pos, f0 + 2);
      chk("b2b_idle_gap", idle_gap, 1);
      chk("b2b_clr_count", nclr, 2);

      // Reset mid-frame: line and busy return immediately, without a clock edge.
      for (int k = 0; k < 15; k++) step(k == 0, (k == 0) ? 8'hC3 : 8'($urandom));
      rst = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("rst_mid_txd%0d", i),  {31'd0, txd_w[i]},  32'd1);
         chk($sformatf("rst_mid_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
         chk($sformatf("rst_mid_clr%0d", i),  {31'd0, clr_w[i]},  32'd0);
      end
      model_reset();
      i_tx_start = 1'b1; i_tx = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      check_outputs("rst_hold");
      rst = 1'b0; i_tx_start = 1'b0;
      run_vec(vecs[7]);

      // Randomized traffic on all instances.
      for (int k = 0; k < 2000; k++) step($urandom_range(0, 7) == 0, 8'($urandom));
      for (int k = 0; k < 60; k++) step(1'b0, 8'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
